// File: rtl/output_pack_pkg.sv
// Shared rotate-engine definitions: byte lanes, packer states, widths and the
// helper that merges a new pixel into the little-endian byte stream.
package output_pack_pkg;

    localparam int PIX_W  = 8;
    localparam int WORD_W = 32;

    localparam int LANE_B = 0;
    localparam int LANE_G = 1;
    localparam int LANE_R = 2;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        PAD   = 2'd1,
        DRAIN = 2'd2
    } opk_state_e;

    // Appends B,G,R above the rcnt residue bytes; [31:0] is the candidate word,
    // [47:32] is what is left over once that word has been emitted.
    function automatic logic [47:0] opk_merge(
        input logic [23:0]      res,
        input logic [1:0]       rcnt,
        input logic [PIX_W-1:0] b,
        input logic [PIX_W-1:0] g,
        input logic [PIX_W-1:0] r
    );
        logic [23:0] pix;
        pix = '0;
        pix[PIX_W*LANE_B +: PIX_W] = b;
        pix[PIX_W*LANE_G +: PIX_W] = g;
        pix[PIX_W*LANE_R +: PIX_W] = r;
        return ({24'h000000, pix} << {rcnt, 3'b000}) | {24'h000000, res};
    endfunction

endpackage

// File: rtl/output_pack_word_fifo.sv
// DEPTH x 32 synchronous first-word-fall-through FIFO. Storage is not reset;
// only pointers and occupancy are.
module opk_word_fifo
    import output_pack_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     hclk,
    input  logic                     hreset_n,
    input  logic                     push,
    input  logic [WORD_W-1:0]        push_data,
    input  logic                     pop,
    output logic [WORD_W-1:0]        pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WORD_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic              do_push;
    logic              do_pop;

    // A push into a full FIFO is legal when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge hclk) begin
        if (!hreset_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge hclk) begin
        if (do_push) mem[wptr] <= push_data;
    end

    assign pop_data = mem[rptr];
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);

endmodule

// File: rtl/output_pack.sv
// Packs B/G/R pixel triples little-endian into 32-bit words and queues them
// for the AHB write path; pads the final partial word and reports completion.
module output_pack
    import output_pack_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              I_OPK_HCLK,
    input  logic              I_OPK_HRESET_N,
    input  logic [PIX_W-1:0]  I_OPK_PIXEL_B,
    input  logic [PIX_W-1:0]  I_OPK_PIXEL_G,
    input  logic [PIX_W-1:0]  I_OPK_PIXEL_R,
    input  logic              I_OPK_PIXEL_VALID,
    output logic              O_OPK_PIXEL_READY,
    input  logic              I_OPK_FLUSH,
    output logic [WORD_W-1:0] O_OPK_WDATA,
    output logic              O_OPK_WVALID,
    input  logic              I_OPK_WREADY,
    output logic              O_OPK_DONE,
    output logic              O_OPK_BUSY
);

    localparam int CW = $clog2(DEPTH) + 1;

    opk_state_e        state;
    opk_state_e        state_nxt;
    logic              live;
    logic [23:0]       res;
    logic [23:0]       res_nxt;
    logic [1:0]        rcnt;
    logic [1:0]        rcnt_nxt;

    logic [CW-1:0]     fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic [WORD_W-1:0] push_data;
    logic              pop;
    logic [WORD_W-1:0] head;

    logic              accept;
    logic [47:0]       merged;
    logic              done_c;

    // live holds READY low through reset and for the release edge itself.
    assign O_OPK_PIXEL_READY = live && (state == RUN) && (fifo_count < CW'(DEPTH));
    assign accept            = I_OPK_PIXEL_VALID && O_OPK_PIXEL_READY;
    assign pop               = !fifo_empty && I_OPK_WREADY;
    assign merged            = opk_merge(res, rcnt, I_OPK_PIXEL_B, I_OPK_PIXEL_G, I_OPK_PIXEL_R);

    always_comb begin
        state_nxt = state;
        res_nxt   = res;
        rcnt_nxt  = rcnt;
        push      = 1'b0;
        push_data = merged[WORD_W-1:0];
        done_c    = 1'b0;
        case (state)
            RUN: begin
                if (accept) begin
                    if (rcnt == 2'd0) begin
                        res_nxt  = merged[23:0];
                        rcnt_nxt = 2'd3;
                    end else begin
                        push     = 1'b1;
                        res_nxt  = {8'h00, merged[47:32]};
                        rcnt_nxt = rcnt - 2'd1;
                    end
                end
                if (I_OPK_FLUSH) begin
                    state_nxt = (rcnt_nxt != 2'd0) ? PAD : DRAIN;
                end
            end
            PAD: begin
                if (!fifo_full || pop) begin
                    push      = 1'b1;
                    push_data = {8'h00, res};
                    res_nxt   = '0;
                    rcnt_nxt  = 2'd0;
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (fifo_empty) begin
                    done_c    = 1'b1;
                    state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge I_OPK_HCLK) begin
        if (!I_OPK_HRESET_N) begin
            state <= RUN;
            live  <= 1'b0;
            res   <= '0;
            rcnt  <= 2'd0;
        end else begin
            state <= state_nxt;
            live  <= 1'b1;
            res   <= res_nxt;
            rcnt  <= rcnt_nxt;
        end
    end

    opk_word_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .hclk      (I_OPK_HCLK),
        .hreset_n  (I_OPK_HRESET_N),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Unwritten storage is never exposed: an empty FIFO presents zero.
    assign O_OPK_WVALID = !fifo_empty;
    assign O_OPK_WDATA  = fifo_empty ? '0 : head;
    assign O_OPK_DONE   = done_c;
    assign O_OPK_BUSY   = (state != RUN) || !fifo_empty || (rcnt != 2'd0);

endmodule

// File: tb/tb_output_pack.sv
// Directed bench for output_pack: packing order, flush/pad, back-pressure,
// full-FIFO push+pop, pointer wrap and mid-frame reset.
module tb_output_pack;

    logic        clk;
    logic        rst_n;
    logic [7:0]  pb, pg, pr;
    logic        valid;
    logic        ready;
    logic        flush;
    logic [31:0] wdata;
    logic        wvalid;
    logic        wready;
    logic        done;
    logic        busy;

    int total = 0;
    int bad   = 0;

    output_pack #(.DEPTH(4)) dut (
        .I_OPK_HCLK        (clk),
        .I_OPK_HRESET_N    (rst_n),
        .I_OPK_PIXEL_B     (pb),
        .I_OPK_PIXEL_G     (pg),
        .I_OPK_PIXEL_R     (pr),
        .I_OPK_PIXEL_VALID (valid),
        .O_OPK_PIXEL_READY (ready),
        .I_OPK_FLUSH       (flush),
        .O_OPK_WDATA       (wdata),
        .O_OPK_WVALID      (wvalid),
        .I_OPK_WREADY      (wready),
        .O_OPK_DONE        (done),
        .O_OPK_BUSY        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_pix(input logic [7:0] b, input logic [7:0] g, input logic [7:0] r);
        pb    = b;
        pg    = g;
        pr    = r;
        valid = 1'b1;
    endtask

    function automatic logic [7:0] sbyte(input int i);
        return 8'((i + 8'h51) & 8'hFF);
    endfunction

    function automatic logic [31:0] sword(input int k);
        return {sbyte(4*k+3), sbyte(4*k+2), sbyte(4*k+1), sbyte(4*k)};
    endfunction

    int sent;
    int popped;
    bit acc;
    bit pop_now;

    initial begin
        rst_n = 1'b0; valid = 1'b0; flush = 1'b0; wready = 1'b1;
        pb = 8'h00; pg = 8'h00; pr = 8'h00;

        // Reset state
        tick(); tick();
        chk("rst_ready",  ready,  0);
        chk("rst_wvalid", wvalid, 0);
        chk("rst_wdata",  wdata,  32'h0);
        chk("rst_done",   done,   0);
        chk("rst_busy",   busy,   0);
        rst_n = 1'b1;
        tick();
        chk("rel_ready",  ready,  1);

        // Four pixels -> three words
        set_pix(8'h01, 8'h02, 8'h03); tick();
        chk("p1_wvalid", wvalid, 0);
        chk("p1_busy",   busy,   1);
        set_pix(8'h04, 8'h05, 8'h06); tick();
        chk("p2_wvalid", wvalid, 1);
        chk("p2_word",   wdata,  32'h04030201);
        set_pix(8'h07, 8'h08, 8'h09); tick();
        chk("p3_word",   wdata,  32'h08070605);
        set_pix(8'h0A, 8'h0B, 8'h0C); tick();
        chk("p4_word",   wdata,  32'h0C0B0A09);
        valid = 1'b0; tick();
        chk("grp_empty", wvalid, 0);
        chk("grp_busy",  busy,   0);

        // Single pixel then flush -> padded word, DONE
        set_pix(8'h11, 8'h22, 8'h33); tick();
        valid = 1'b0;
        chk("one_busy", busy, 1);
        flush = 1'b1; tick(); flush = 1'b0;
        chk("pad_ready",  ready,  0);
        chk("pad_wvalid", wvalid, 0);
        tick();
        chk("pad_word",   wdata,  32'h00332211);
        chk("pad_done0",  done,   0);
        tick();
        chk("pad_drained", wvalid, 0);
        chk("pad_done",    done,   1);
        tick();
        chk("pad_done_off", done,  0);
        chk("pad_idle",     busy,  0);
        chk("pad_ready_rt", ready, 1);

        // Flush with the fourth pixel -> no pad word
        set_pix(8'h21, 8'h22, 8'h23); tick();
        set_pix(8'h24, 8'h25, 8'h26); tick();
        chk("f4_w0", wdata, 32'h24232221);
        set_pix(8'h27, 8'h28, 8'h29); tick();
        chk("f4_w1", wdata, 32'h28272625);
        set_pix(8'h2A, 8'h2B, 8'h2C); flush = 1'b1; tick();
        valid = 1'b0; flush = 1'b0;
        chk("f4_w2",    wdata, 32'h2C2B2A29);
        chk("f4_done0", done,  0);
        tick();
        chk("f4_nopad", wvalid, 0);
        chk("f4_done",  done,   1);
        tick();
        chk("f4_idle",  busy,   0);

        // Back-pressure: READY falls after the 6th pixel, held 7th pixel
        wready = 1'b0;
        set_pix(8'h31, 8'h32, 8'h33); tick();
        set_pix(8'h34, 8'h35, 8'h36); tick();
        set_pix(8'h37, 8'h38, 8'h39); tick();
        set_pix(8'h3A, 8'h3B, 8'h3C); tick();
        set_pix(8'h3D, 8'h3E, 8'h3F); tick();
        set_pix(8'h40, 8'h41, 8'h42); tick();
        chk("bp_ready_low", ready, 0);
        chk("bp_head",      wdata, 32'h34333231);
        set_pix(8'h43, 8'h44, 8'h45); tick();
        chk("bp_hold_ready", ready, 0);
        chk("bp_hold_head",  wdata, 32'h34333231);
        wready = 1'b1; tick(); wready = 1'b0;
        chk("bp_ready_back", ready, 1);
        chk("bp_pop_head",   wdata, 32'h38373635);
        tick();
        valid = 1'b0;
        chk("bp_refull", ready, 0);
        wready = 1'b1; tick();
        chk("bp_w2", wdata, 32'h3C3B3A39);
        tick();
        chk("bp_w3", wdata, 32'h403F3E3D);
        tick();
        chk("bp_w4", wdata, 32'h44434241);
        tick();
        chk("bp_empty", wvalid, 0);
        chk("bp_resid", busy,   1);
        flush = 1'b1; tick(); flush = 1'b0;
        tick();
        chk("bp_pad", wdata, 32'h00000045);
        tick();
        chk("bp_done", done, 1);
        tick();

        // PAD while full: push and pop in the same cycle
        wready = 1'b0;
        set_pix(8'h61, 8'h62, 8'h63); tick();
        set_pix(8'h64, 8'h65, 8'h66); tick();
        set_pix(8'h67, 8'h68, 8'h69); tick();
        set_pix(8'h6A, 8'h6B, 8'h6C); tick();
        set_pix(8'h6D, 8'h6E, 8'h6F); tick();
        set_pix(8'h70, 8'h71, 8'h72); tick();
        valid = 1'b0;
        flush = 1'b1; tick(); flush = 1'b0;
        tick();
        chk("pf_stall_head", wdata, 32'h64636261);
        chk("pf_stall_busy", busy,  1);
        chk("pf_stall_done", done,  0);
        wready = 1'b1; tick();
        chk("pf_w1",  wdata, 32'h68676665);
        tick();
        chk("pf_w2",  wdata, 32'h6C6B6A69);
        tick();
        chk("pf_w3",  wdata, 32'h706F6E6D);
        tick();
        chk("pf_pad", wdata, 32'h00007271);
        tick();
        chk("pf_empty", wvalid, 0);
        chk("pf_done",  done,   1);
        tick();
        chk("pf_idle",  busy,   0);

        // Streaming across pointer wrap: 16 pixels -> 12 words
        sent = 0; popped = 0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            wready = (cyc >= 8);
            valid  = (sent < 16);
            pb = sbyte(3*sent); pg = sbyte(3*sent+1); pr = sbyte(3*sent+2);
            if (cyc == 7) begin
                chk("st_full_ready", ready, 0);
                chk("st_full_sent",  sent,  6);
            end
            acc     = valid && ready;
            pop_now = wvalid && wready;
            if (pop_now) begin
                chk($sformatf("st_word%0d", popped), wdata, sword(popped));
                popped++;
            end
            tick();
            if (acc) sent++;
            if (popped == 12 && sent == 16) break;
        end
        valid = 1'b0;
        chk("st_popped", popped, 12);
        tick();
        chk("st_idle", busy, 0);

        // Mid-frame reset with 3 words queued and rcnt=2
        wready = 1'b0;
        set_pix(8'h81, 8'h82, 8'h83); tick();
        set_pix(8'h84, 8'h85, 8'h86); tick();
        set_pix(8'h87, 8'h88, 8'h89); tick();
        set_pix(8'h8A, 8'h8B, 8'h8C); tick();
        set_pix(8'h8D, 8'h8E, 8'h8F); tick();
        set_pix(8'h90, 8'h91, 8'h92); tick();
        valid = 1'b0;
        wready = 1'b1; tick(); wready = 1'b0;
        chk("mr_pre_head", wdata, 32'h88878685);
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        chk("mr_wvalid", wvalid, 0);
        chk("mr_busy",   busy,   0);
        chk("mr_done",   done,   0);
        tick();
        chk("mr_ready",  ready,  1);
        chk("mr_done2",  done,   0);
        set_pix(8'hAA, 8'hBB, 8'hCC); flush = 1'b1; tick();
        valid = 1'b0; flush = 1'b0;
        tick();
        chk("mr_word",   wdata,  32'h00CCBBAA);
        chk("mr_wvalid2", wvalid, 1);
        wready = 1'b1; tick();
        chk("mr_fdone",  done,   1);
        tick();
        chk("mr_idle",   busy,   0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/output_pack.md
# output_pack

Downstream neighbour of the rotate engine's input pixel buffer. Consumes one B/G/R pixel triple per cycle as the buffer reads it out, packs the byte stream little-endian into 32-bit words (4 pixels become 3 words), and queues the words in a small FIFO for the AHB master's write path. It applies back-pressure to the pixel reader and signals frame completion once every word has drained.

## Interface
- DEPTH, 4: word FIFO depth in entries (power of two, ≥2)
- I_OPK_HCLK  input  1  system clock; all logic on rising edge
- I_OPK_HRESET_N  input  1  reset; synchronous, active-low
- I_OPK_PIXEL_B  input  8  blue byte, first in stream order
- I_OPK_PIXEL_G  input  8  green byte
- I_OPK_PIXEL_R  input  8  red byte (0x00 when the upstream pads)
- I_OPK_PIXEL_VALID  input  1  pixel triple present
- O_OPK_PIXEL_READY  output  1  block can accept a triple this cycle
- I_OPK_FLUSH  input  1  single-cycle end-of-frame pulse
- O_OPK_WDATA  output  32  head-of-FIFO word
- O_OPK_WVALID  output  1  FIFO non-empty
- I_OPK_WREADY  input  1  AHB side consumes the head word this cycle
- O_OPK_DONE  output  1  one-cycle pulse: frame flushed and drained
- O_OPK_BUSY  output  1  state ≠ RUN or FIFO non-empty or residue ≠ 0

## Operation
- Byte order within a pixel: B, G, R. The first stream byte lands in WDATA[7:0]. Pixels (01,02,03),(04,05,06) therefore start word 0x04030201.
- Residue register: 0–3 leftover bytes plus a 2-bit count rcnt.
- Accept: when VALID && READY, total = rcnt+3. If total ≥ 4, push word (residue bytes, then new bytes) and rcnt ← total−4. Otherwise rcnt ← 3. Cycle of rcnt over four pixels: 0→3→2→1→0.
- Pop: when WVALID && WREADY, the head advances. Push and pop may occur in the same cycle, including with the FIFO full.
- READY = (state == RUN) && (fifo_count < DEPTH).
- VALID without READY: the triple is not taken. Upstream holds it.
- States:
  - RUN: normal packing. On FLUSH, any same-cycle accepted pixel is processed first. Then: rcnt after that ≠ 0 → PAD; else → DRAIN. FLUSH is ignored outside RUN.
  - PAD: when fifo_count < DEPTH (or a pop occurs this cycle), push residue zero-extended in the upper bytes, rcnt ← 0, → DRAIN.
  - DRAIN: when the FIFO is empty, pulse DONE for one cycle, → RUN.
- fifo_count width is clog2(DEPTH)+1. Read/write pointers wrap modulo DEPTH.

## Timing
- Reset values: READY 0 during reset, then 1 the cycle after reset releases (RUN, empty FIFO); WDATA 0x00000000; WVALID 0; DONE 0; BUSY 0. Residue, rcnt, pointers and count are cleared. State = RUN.
- Latency: a word completed by a pixel accepted at edge N is visible on WDATA/WVALID after edge N (first-word fall-through, registered storage, no combinational VALID→WVALID path).
- READY is a function of registered state only, so it has no combinational dependence on WREADY.
- DONE asserts the cycle after the final pop empties the FIFO. If the FIFO is already empty on entering DRAIN, DONE asserts the cycle after entry.
- Reset mid-frame takes effect at the next edge: residue and FIFO contents are discarded and no DONE is produced.

## Structure
- Shared rotate package: byte-lane constants (LANE_B=0, LANE_G=1, LANE_R=2), the state enum (RUN, PAD, DRAIN), and the pixel/word width constants (8, 32).
- Sub-module opk_word_fifo: parameterised DEPTH × 32 synchronous FIFO with push, pop, count, full and empty. It is reusable for the read-side prefetch. The packer and FSM stay in the top level.

## Test plan
- Reset, then 4 pixels (01,02,03),(04,05,06),(07,08,09),(0A,0B,0C) with WREADY=1 → words 0x04030201, 0x08070605, 0x0C0B0A09; rcnt 0.
- 1 pixel (11,22,33) then FLUSH → one word 0x00332211, then DONE for one cycle; BUSY low afterwards.
- FLUSH in the same cycle as the 4th pixel of a group → 3 words, no pad word, DONE after drain.
- WREADY=0, stream pixels with DEPTH=4 → READY falls once the 4th word is queued (after the 6th pixel; rcnt=2). Raise WREADY for one cycle → one pop, READY returns, no data lost or reordered.
- Simultaneous push and pop while full across pointer wrap (more than 8 words) → order preserved, count stable.
- Reset asserted mid-frame with 3 words queued and rcnt=2 → next cycle WVALID 0, READY 1, BUSY 0, no DONE. A subsequent pixel (AA,BB,CC) with flush → 0x00CCBBAA.
